// File: rtl/stepper_phase_monitor.sv
// Receive-side monitor for the ULN2003 half-step coil pattern: tracks step direction,
// absolute position and floor, and flags illegal patterns, skipped phases and range overrun.
module stepper_phase_monitor #(
  parameter int unsigned STEPS_PER_FLOOR = 8,
  parameter int unsigned FLOORS          = 3,
  parameter int unsigned POS_W           = 16,
  parameter int unsigned IDLE_CYCLES     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       phase,
  input  logic             home,
  input  logic             err_clr,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       floor,
  output logic             at_floor,
  output logic             step_pulse,
  output logic             dir_up,
  output logic             moving,
  output logic             err_illegal,
  output logic             err_skip,
  output logic             err_range
);

  localparam int unsigned SUB_W  = $clog2(STEPS_PER_FLOOR);
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [POS_W-1:0]  TOP       = POS_W'((FLOORS - 1) * STEPS_PER_FLOOR);
  localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'(STEPS_PER_FLOOR - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

  typedef enum logic {UNSYNC, TRACK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        phase_q;
  logic [2:0]        last_q, last_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [POS_W-1:0]  pos_d;
  logic [1:0]        flr_d;
  logic              dir_d, pulse_d, at_d;
  logic              ill_ev, skip_ev, rng_ev, up_try, dn_try;
  logic              vld;
  logic [2:0]        idx, delta;
  logic [IDLE_W-1:0] idle_q;

  always_comb begin
    vld = 1'b1;
    idx = '0;
    unique case (phase_q)
      4'b1000: idx = 3'd0;
      4'b1100: idx = 3'd1;
      4'b0100: idx = 3'd2;
      4'b0110: idx = 3'd3;
      4'b0010: idx = 3'd4;
      4'b0011: idx = 3'd5;
      4'b0001: idx = 3'd6;
      4'b1001: idx = 3'd7;
      default: vld = 1'b0;
    endcase
  end

  assign delta = idx - last_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pos_d   = pos;
    sub_d   = sub_q;
    flr_d   = floor;
    dir_d   = dir_up;
    pulse_d = 1'b0;
    ill_ev  = 1'b0;
    skip_ev = 1'b0;
    rng_ev  = 1'b0;
    up_try  = 1'b0;
    dn_try  = 1'b0;
    unique case (state_q)
      UNSYNC: begin
        if (vld) begin
          last_d  = idx;
          state_d = TRACK;
        end else if (phase_q != '0) begin
          ill_ev = 1'b1;
        end
      end
      TRACK: begin
        if (!vld) begin
          if (phase_q != '0) begin
            ill_ev  = 1'b1;
            state_d = UNSYNC;
          end
        end else if (idx != last_q) begin
          last_d = idx;
          if (delta == 3'd1)      up_try  = 1'b1;
          else if (delta == 3'd7) dn_try  = 1'b1;
          else                    skip_ev = 1'b1;
        end
      end
      default: state_d = UNSYNC;
    endcase

    // home swallows a coincident step entirely, but the pattern is still consumed into last_idx
    if (up_try && !home) begin
      dir_d = 1'b1;
      if (pos == TOP) begin
        rng_ev = 1'b1;
      end else begin
        pos_d   = pos + 1'b1;
        pulse_d = 1'b1;
        if (sub_q == SUB_MAX) begin
          sub_d = '0;
          flr_d = floor + 2'd1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
    end
    if (dn_try && !home) begin
      dir_d = 1'b0;
      if (pos == '0) begin
        rng_ev = 1'b1;
      end else begin
        pos_d   = pos - 1'b1;
        pulse_d = 1'b1;
        if (sub_q == '0) begin
          sub_d = SUB_MAX;
          flr_d = floor - 2'd1;
        end else begin
          sub_d = sub_q - 1'b1;
        end
      end
    end
    if (home) begin
      pos_d = '0;
      sub_d = '0;
      flr_d = '0;
    end
    at_d = (sub_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNSYNC;
      phase_q     <= '0;
      last_q      <= '0;
      pos         <= '0;
      sub_q       <= '0;
      floor       <= '0;
      at_floor    <= 1'b0;
      step_pulse  <= 1'b0;
      dir_up      <= 1'b0;
      moving      <= 1'b0;
      idle_q      <= '0;
      err_illegal <= 1'b0;
      err_skip    <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase;
      last_q      <= last_d;
      pos         <= pos_d;
      sub_q       <= sub_d;
      floor       <= flr_d;
      at_floor    <= at_d;
      step_pulse  <= pulse_d;
      dir_up      <= dir_d;
      err_illegal <= (err_illegal & ~err_clr) | ill_ev;
      err_skip    <= (err_skip & ~err_clr) | skip_ev;
      err_range   <= (err_range & ~err_clr) | rng_ev;
      if (pulse_d) begin
        idle_q <= '0;
        moving <= 1'b1;
      end else if (idle_q != IDLE_MAX) begin
        idle_q <= idle_q + 1'b1;
        if (idle_q == IDLE_LAST) moving <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// Directed bench for stepper_phase_monitor: a vector table of held coil patterns with
// hand-computed position/floor/flag expectations, plus hand sequences for reset, home and idle.
module tb_stepper_phase_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  phase;
  logic        home;
  logic        err_clr;
  logic [15:0] pos;
  logic [1:0]  floor;
  logic        at_floor, step_pulse, dir_up, moving;
  logic        err_illegal, err_skip, err_range;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stepper_phase_monitor #(
    .STEPS_PER_FLOOR(8),
    .FLOORS(3),
    .POS_W(16),
    .IDLE_CYCLES(1000)
  ) dut (
    .clk(clk), .rst(rst), .phase(phase), .home(home), .err_clr(err_clr),
    .pos(pos), .floor(floor), .at_floor(at_floor), .step_pulse(step_pulse),
    .dir_up(dir_up), .moving(moving), .err_illegal(err_illegal),
    .err_skip(err_skip), .err_range(err_range)
  );

  typedef struct {
    logic [3:0]  ph;
    logic        clr;
    logic [15:0] pos;
    logic [1:0]  flr;
    logic        at;
    logic        dir;
    int          pulses;
    logic [2:0]  err;   // {illegal, skip, range}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] ph, input logic clr, input int p, input int f,
                     input logic at, input logic dir, input int pulses, input logic [2:0] err);
    vec_t v;
    v.ph = ph; v.clr = clr; v.pos = 16'(p); v.flr = 2'(f); v.at = at; v.dir = dir;
    v.pulses = pulses; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, counting step pulses; err_clr (if set) is dropped after the first cycle.
  task automatic run(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      err_clr = 1'b0;
      home    = 1'b0;
      if (step_pulse) p++;
    end
  endtask

  function automatic logic [9:0] all_out();
    return {at_floor, step_pulse, dir_up, moving, err_illegal, err_skip, err_range,
            floor, |pos};
  endfunction

  initial begin
    int p;
    logic [3:0] ups[5];
    rst = 1'b1; phase = 4'b0000; home = 1'b0; err_clr = 1'b0;

    // 1..2: climb through all floors into the top limit
    add(4'b1000,0, 0,0,1,0,0,3'b000);
    add(4'b1100,0, 1,0,0,1,1,3'b000);
    add(4'b0100,0, 2,0,0,1,1,3'b000);
    add(4'b0110,0, 3,0,0,1,1,3'b000);
    add(4'b0010,0, 4,0,0,1,1,3'b000);
    add(4'b0011,0, 5,0,0,1,1,3'b000);
    add(4'b0001,0, 6,0,0,1,1,3'b000);
    add(4'b1001,0, 7,0,0,1,1,3'b000);
    add(4'b1000,0, 8,1,1,1,1,3'b000);
    add(4'b1100,0, 9,1,0,1,1,3'b000);
    add(4'b0100,0,10,1,0,1,1,3'b000);
    add(4'b0110,0,11,1,0,1,1,3'b000);
    add(4'b0010,0,12,1,0,1,1,3'b000);
    add(4'b0011,0,13,1,0,1,1,3'b000);
    add(4'b0001,0,14,1,0,1,1,3'b000);
    add(4'b1001,0,15,1,0,1,1,3'b000);
    add(4'b1000,0,16,2,1,1,1,3'b000);
    add(4'b1100,0,16,2,1,1,0,3'b001);
    add(4'b1000,0,15,1,0,0,1,3'b001);
    add(4'b1001,1,14,1,0,0,1,3'b000);
    // walk down to 1100 at pos 8, then skip by 2 and recover
    add(4'b0001,0,13,1,0,0,1,3'b000);
    add(4'b0011,0,12,1,0,0,1,3'b000);
    add(4'b0010,0,11,1,0,0,1,3'b000);
    add(4'b0110,0,10,1,0,0,1,3'b000);
    add(4'b0100,0, 9,1,0,0,1,3'b000);
    add(4'b1100,0, 8,1,1,0,1,3'b000);
    add(4'b0110,0, 8,1,1,0,0,3'b010);
    add(4'b0010,0, 9,1,0,1,1,3'b010);
    // illegal pattern drops sync; next legal pattern only resyncs
    add(4'b1010,0, 9,1,0,1,0,3'b110);
    add(4'b0100,0, 9,1,0,1,0,3'b110);
    add(4'b0110,1,10,1,0,1,1,3'b000);

    tick(); tick();
    chk("reset_outputs", 32'(all_out()), 32'd0);
    chk("reset_pos", 32'(pos), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      phase   = vecs[i].ph;
      err_clr = vecs[i].clr;
      run(4, p);
      chk($sformatf("v%0d_pos", i), 32'(pos), 32'(vecs[i].pos));
      chk($sformatf("v%0d_floor", i), 32'(floor), 32'(vecs[i].flr));
      chk($sformatf("v%0d_at_floor", i), 32'(at_floor), 32'(vecs[i].at));
      chk($sformatf("v%0d_dir_up", i), 32'(dir_up), 32'(vecs[i].dir));
      chk($sformatf("v%0d_pulses", i), 32'(p), 32'(vecs[i].pulses));
      chk($sformatf("v%0d_errs", i), 32'({err_illegal, err_skip, err_range}), 32'(vecs[i].err));
    end

    // reset mid-move, then the held pattern must resync rather than count
    rst = 1'b1;
    tick(); tick();
    chk("midrst_outputs", 32'(all_out()), 32'd0);
    chk("midrst_pos", 32'(pos), 32'd0);
    rst = 1'b0;
    run(4, p);
    chk("resync_pulses", 32'(p), 32'd0);
    chk("resync_pos", 32'(pos), 32'd0);
    phase = 4'b0010;
    run(4, p);
    chk("post_rst_step_pos", 32'(pos), 32'd1);
    chk("post_rst_step_pulses", 32'(p), 32'd1);

    // home with the pattern held: position zeroed, direction kept
    home = 1'b1;
    run(1, p);
    chk("home_pos", 32'(pos), 32'd0);
    chk("home_at_floor", 32'(at_floor), 32'd1);
    chk("home_dir_kept", 32'(dir_up), 32'd1);

    ups[0] = 4'b0011; ups[1] = 4'b0001; ups[2] = 4'b1001; ups[3] = 4'b1000; ups[4] = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      phase = ups[i];
      run(4, p);
      chk($sformatf("climb%0d_pos", i), 32'(pos), 32'(i + 1));
    end

    phase = 4'b0000;
    run(20, p);
    chk("coils_off_pulses", 32'(p), 32'd0);
    chk("coils_off_pos", 32'(pos), 32'd5);
    phase = 4'b1000;
    run(4, p);
    chk("after_off_down_pos", 32'(pos), 32'd4);
    chk("after_off_down_dir", 32'(dir_up), 32'd0);
    chk("after_off_pulses", 32'(p), 32'd1);
    chk("moving_after_step", 32'(moving), 32'd1);

    // home coinciding with a step reaching stage 2: home wins, no pulse
    phase = 4'b1001;
    tick();
    home = 1'b1;
    run(1, p);
    chk("home_step_pos", 32'(pos), 32'd0);
    chk("home_step_pulse", 32'(p), 32'd0);
    chk("home_step_at_floor", 32'(at_floor), 32'd1);
    run(4, p);
    chk("home_step_no_late_pulse", 32'(p), 32'd0);
    chk("home_step_pos_hold", 32'(pos), 32'd0);
    chk("errs_clean", 32'({err_illegal, err_skip, err_range}), 32'd0);

    run(990, p);
    chk("moving_before_idle", 32'(moving), 32'd1);
    run(20, p);
    chk("moving_idle_clear", 32'(moving), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
